// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the RX pin, centre-samples each bit with a
// baud counter and reports either a received byte or a framing error.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 960000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       uart_busy
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF    = BPS_CNT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_n;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_n;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic                done_q, done_n;
  logic                ferr_q, ferr_n;
  logic                busy_q, busy_n;

  logic rxd_d0, rxd_d1, rxd_prev;
  logic rxd_s;
  logic start_edge;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_d0   <= 1'b1;
      rxd_d1   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_d0   <= uart_rxd;
      rxd_d1   <= rxd_d0;
      rxd_prev <= rxd_d1;
    end
  end

  assign rxd_s      = rxd_d1;
  assign start_edge = !rxd_s && rxd_prev;

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      clk_cnt_q <= clk_cnt_n;
      bit_cnt_q <= bit_cnt_n;
      shift_q   <= shift_n;
      data_q    <= data_n;
      done_q    <= done_n;
      ferr_q    <= ferr_n;
      busy_q    <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_q;
    clk_cnt_n = clk_cnt_q + CNT_W'(1);
    bit_cnt_n = bit_cnt_q;
    shift_n   = shift_q;
    data_n    = data_q;
    done_n    = 1'b0;
    ferr_n    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_n = '0;
        if (start_edge) begin
          state_n = START;
        end
      end

      START: begin
        // A line already back high at mid-start is treated as noise
        if (clk_cnt_q == CNT_HALF && rxd_s) begin
          state_n   = IDLE;
          clk_cnt_n = '0;
        end else if (clk_cnt_q == CNT_LAST) begin
          state_n   = DATA;
          clk_cnt_n = '0;
          bit_cnt_n = '0;
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_HALF) begin
          shift_n[bit_cnt_q] = rxd_s;
        end
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_n = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      STOP: begin
        // Return at mid-stop so a back-to-back start edge is not missed
        if (clk_cnt_q == CNT_HALF) begin
          state_n   = IDLE;
          clk_cnt_n = '0;
          if (rxd_s) begin
            data_n = shift_q;
            done_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end

      default: begin
        state_n   = IDLE;
        clk_cnt_n = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign uart_data = data_q;
  assign uart_done = done_q;
  assign frame_err = ferr_q;
  assign uart_busy = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 frames, the receive-side counterpart of the team's `uart_tx` transmitter. It synchronises the asynchronous `uart_rxd` line and detects start bits. Each bit is sampled at its centre using a baud counter, and a completed byte is presented with a one-cycle done strobe. Framing errors and start-bit glitches are flagged or rejected. It sits between the board RX pin and downstream byte consumers, and is used in loopback against `uart_tx` at the same `UART_BPS`.

## Interface
- `CLK_FREQ`, default 50000000: `sys_clk` frequency in Hz.
- `UART_BPS`, default 960000: baud rate.
- Derived `BPS_CNT` = `CLK_FREQ/UART_BPS`, using integer truncation (52 at the defaults). `HALF` = `BPS_CNT/2` (26). `BPS_CNT` must be at least 4.
- `sys_clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `sys_rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `uart_rxd`, input, 1 bit: serial line. It idles high and is asynchronous to `sys_clk`.
- `uart_data`, output, 8 bits: last correctly framed byte, held until the next good frame.
- `uart_done`, output, 1 bit: one-cycle pulse when `uart_data` has just been updated.
- `frame_err`, output, 1 bit: one-cycle pulse when the stop bit was sampled low.
- `uart_busy`, output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Synchroniser:** two flops, `rxd_d0` then `rxd_d1`; the synchronised line is `rxd_s` = `rxd_d1`. A third flop, `rxd_prev`, holds `rxd_s` delayed by one cycle. All three reset to 1.
- **Start edge:** `start_edge` = `!rxd_s && rxd_prev`. It is acted on only in IDLE.
- **Registers:**
  - `clk_cnt` is 16 bits and counts 0..`BPS_CNT`-1 within each bit.
  - `bit_cnt` is 3 bits.
  - `shift` is 8 bits.
- **IDLE:**
  - On `start_edge`: go to START and set `clk_cnt` to 0.
  - Otherwise `clk_cnt` is held at 0.
- **START:**
  - At `clk_cnt`==`HALF`, if `rxd_s`==1 the start is a glitch: return to IDLE with no pulse.
  - At `clk_cnt`==`BPS_CNT`-1: go to DATA, clear `clk_cnt` and set `bit_cnt` to 0.
- **DATA:**
  - At `clk_cnt`==`HALF`: `shift[bit_cnt]` <= `rxd_s`. Bits are received LSB first.
  - At `clk_cnt`==`BPS_CNT`-1: clear `clk_cnt`. If `bit_cnt`==7 go to STOP, otherwise increment `bit_cnt`.
- **STOP:**
  - At `clk_cnt`==`HALF`, if `rxd_s`==1: `uart_data` <= `shift` and `uart_done` <= 1.
  - At `clk_cnt`==`HALF`, if `rxd_s`==0: `frame_err` <= 1 and `uart_data` is unchanged.
  - In both cases go to IDLE in the same edge. Leaving at mid-stop lets the receiver catch a back-to-back start bit.
- **Pulse outputs:** `uart_done` and `frame_err` are registered and high for exactly one cycle. They are never high together.
- **Break (line held low):**
  - START passes and the data bits are all 0.
  - The stop bit is 0, so `frame_err` fires and the state returns to IDLE.
  - No further frame starts until `rxd_s` returns high and falls again.
- **Reset values:**
  - All outputs are 0.
  - State is IDLE; counters and `shift` are 0.
  - Synchroniser flops are 1.
- **Reset mid-frame:** the frame is abandoned immediately with no pulse.
  - If the line is low at reset release, the synchroniser sees a falling edge and starts a frame.
  - That frame ends in `frame_err` or a spurious byte. This is accepted behaviour.

## Timing
- **Pin to start:** a falling edge on `uart_rxd` reaches `rxd_s` after 2 cycles. `start_edge` is seen in the same cycle, and START is entered the next cycle, called cycle t0, with `clk_cnt`=0.
- **Sample points:** data bit k (k = 0..7) is sampled at cycle t0 + (k+1)·`BPS_CNT` + `HALF`.
- **Stop sample:** at cycle t0 + 9·`BPS_CNT` + `HALF`.
- **Output pulse:** `uart_done` or `frame_err` is high in cycle t0 + 9·`BPS_CNT` + `HALF` + 1, which is t0+495 at the defaults. `uart_data` is valid from that same cycle.
- **`uart_busy`:** rises at t0 and falls in the cycle the pulse rises.
- **Glitch:** `uart_busy` falls at t0 + `HALF` + 1.
- **Baud tolerance:** the centre sample tolerates a cumulative drift of up to ±`HALF`-1 cycles by the stop bit, i.e. roughly ±4.5 % per bit.

## Test plan
- **Reset values:** assert `sys_rst_n`=0 with `uart_rxd`=1. Required: `uart_data`=0x00 and `uart_done`=`frame_err`=`uart_busy`=0. After release, 100 idle cycles produce no pulses.
- **Single frame:** drive 0x55 at 52 clocks per bit with stop bit = 1. Required: `uart_done` high for exactly 1 cycle at t0+495, `uart_data`=0x55, `frame_err` stays 0.
- **Back-to-back and baud tolerance:**
  - Drive 0xA3 then 0x00 with a single stop bit and no idle gap between them. Required: two `uart_done` pulses, carrying 0xA3 then 0x00.
  - Repeat with 0xC6 at 50 and at 54 clocks per bit. Required: 0xC6 is received correctly in both cases.
- **Glitch rejection:** drive a low pulse of 10 cycles. Required: no `uart_done` or `frame_err`, and `uart_busy` is 0 again by t0+27.
- **Framing error:** receive 0x12, then send 0xFF with stop bit = 0. Required: `frame_err` is a one-cycle pulse, `uart_done` stays 0, `uart_data` remains 0x12.
- **Break:** hold the line low for 20 bit times. Required: exactly one `frame_err` pulse.
- **Reset mid-frame:** assert reset during bit 4 of a frame, and release it with the line high. Required: outputs return to reset values with no pulse. A following clean 0x3C frame is received with `uart_data`=0x3C.
